// File: rtl/matrix_mult_core.sv
// matrix_mult_core: square NxN unsigned matrix multiplier, C = A x B, with on-chip A/B/C memories
//   clk, reset (async, active-high)
//   load_mem            host owns A/B writes and C clears while high (honoured in IDLE/DONE only)
//   start               starts a computation when load_mem=0 in IDLE or DONE
//   wenA/wdA/addrA      host write port of A (row-major)
//   wenB/wdB/addrB      host write port of B (row-major)
//   wenC/addrC          host clear of C[addrC]; addrC also drives the read port
//   rdC                 registered read data C[addrC], 1-cycle latency
//   done                level, set when C is complete, cleared by the next accepted start
module matrix_mult_core #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int CW = 2*DW + $clog2(N),
    parameter int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_mem,
    input  logic          start,
    input  logic          wenA,
    input  logic          wenB,
    input  logic          wenC,
    input  logic [DW-1:0] wdA,
    input  logic [DW-1:0] wdB,
    input  logic [AW-1:0] addrA,
    input  logic [AW-1:0] addrB,
    input  logic [AW-1:0] addrC,
    output logic [CW-1:0] rdC,
    output logic          done
);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] a_mem [N*N];
    logic [DW-1:0] b_mem [N*N];
    logic [CW-1:0] c_mem [N*N];
    logic [KW-1:0] i, j, k;
    logic [CW-1:0] acc;

    logic          idle_like, go, host, last_k, last_j, last_i;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [CW-1:0] prod;

    assign idle_like = (state == IDLE) || (state == DONE);
    // load_mem has priority over start, and host access is locked out while computing
    assign go     = idle_like && start && !load_mem;
    assign host   = idle_like && load_mem;
    assign last_k = k == KW'(N-1);
    assign last_j = j == KW'(N-1);
    assign last_i = i == KW'(N-1);
    assign a_addr = AW'(i*N + k);
    assign b_addr = AW'(k*N + j);
    assign c_addr = AW'(i*N + j);
    assign prod   = CW'(a_mem[a_addr]) * CW'(b_mem[b_addr]);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go ? MAC : state;
            MAC:        state_n = last_k ? WRITE : MAC;
            WRITE:      state_n = (last_i && last_j) ? DONE : MAC;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            rdC   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            rdC   <= c_mem[addrC];
            if (go) begin
                done <= 1'b0;
                i    <= '0;
                j    <= '0;
                k    <= '0;
                acc  <= '0;
            end
            if (state == MAC) begin
                acc <= acc + prod;
                k   <= last_k ? '0 : k + 1'b1;
            end
            if (state == WRITE) begin
                acc <= '0;
                k   <= '0;
                j   <= last_j ? '0 : j + 1'b1;
                if (last_j)
                    i <= last_i ? '0 : i + 1'b1;
                if (last_i && last_j)
                    done <= 1'b1;
            end
        end
    end

    // memory arrays carry no reset
    always_ff @(posedge clk) begin
        if (host && wenA)
            a_mem[addrA] <= wdA;
        if (host && wenB)
            b_mem[addrB] <= wdB;
        if (state == WRITE)
            c_mem[c_addr] <= acc;
        else if (host && wenC)
            c_mem[addrC] <= '0;
    end
endmodule

// File: tb/tb_matrix_mult_core.sv
// tb_matrix_mult_core: scoreboard bench for matrix_mult_core with directed matrices
module tb_matrix_mult_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_mem = 1'b0, start = 1'b0;
    logic        wenA = 1'b0, wenB = 1'b0, wenC = 1'b0;
    logic [7:0]  wdA = '0, wdB = '0;
    logic [3:0]  addrA = '0, addrB = '0, addrC = '0;
    logic [17:0] rdC;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    int          ma [16];
    int          mb [16];
    int          exp_q [$];
    logic        rd_pend = 1'b0;
    logic        rd_d = 1'b0;

    matrix_mult_core dut (
        .clk(clk), .reset(reset), .load_mem(load_mem), .start(start),
        .wenA(wenA), .wenB(wenB), .wenC(wenC), .wdA(wdA), .wdB(wdB),
        .addrA(addrA), .addrB(addrB), .addrC(addrC), .rdC(rdC), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // a read issued before a posedge appears on rdC after that posedge
    always @(posedge clk) rd_d <= rd_pend;

    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rdC_unexpected actual=%0d expected=none", rdC);
            end else begin
                chk("rdC", int'(rdC), exp_q.pop_front());
            end
        end
    end

    task automatic load_ab(input logic with_start);
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            load_mem = 1'b1; start = with_start;
            wenA = 1'b1; wenB = 1'b1;
            addrA = 4'(n); addrB = 4'(n);
            wdA = 8'(ma[n]); wdB = 8'(mb[n]);
        end
        @(posedge clk); #1;
        load_mem = 1'b0; start = 1'b0; wenA = 1'b0; wenB = 1'b0;
    endtask

    task automatic run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("done_after_start", int'(done), 0);
        repeat (79) @(posedge clk);
        #1 chk("done_at_79", int'(done), 0);
        @(posedge clk);
        #1 chk("done_at_80", int'(done), 1);
    endtask

    task automatic rd(input int a, input int exp);
        @(posedge clk); #1;
        addrC = 4'(a);
        rd_pend = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic rd_end();
        @(posedge clk); #1 rd_pend = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("reset_done", int'(done), 0);
        chk("reset_rdC", int'(rdC), 0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #2;
        chk("por_done", int'(done), 0);
        chk("por_rdC", int'(rdC), 0);
        @(posedge clk); #1 reset = 1'b0;

        // identity x index matrix
        for (int n = 0; n < 16; n++) begin
            ma[n] = (n / 4 == n % 4) ? 1 : 0;
            mb[n] = n;
        end
        load_ab(1'b0);
        run();
        for (int n = 0; n < 16; n++) rd(n, n);
        rd_end();

        // constant 2 x constant 3
        for (int n = 0; n < 16; n++) begin ma[n] = 2; mb[n] = 3; end
        load_ab(1'b0);
        run();
        for (int n = 0; n < 16; n++) rd(n, 24);
        rd_end();
        repeat (10) @(posedge clk);
        #1 chk("done_held", int'(done), 1);

        // back-to-back: new B loaded in DONE, C[r][c] = 2*sum_k(4k+c) = 48+8c
        for (int n = 0; n < 16; n++) mb[n] = n;
        load_ab(1'b0);
        chk("done_held_load", int'(done), 1);
        run();
        for (int n = 0; n < 16; n++) rd(n, 48 + 8*(n % 4));
        rd_end();

        // priority: start with load_mem=1 is ignored; C is not reset
        pulse_reset();
        for (int n = 0; n < 16; n++) begin ma[n] = 255; mb[n] = 255; end
        load_ab(1'b1);
        repeat (85) @(posedge clk);
        #1 chk("prio_done", int'(done), 0);
        rd(0, 48);
        rd(3, 72);
        rd_end();

        // max values
        run();
        for (int n = 0; n < 16; n++) rd(n, 260100);
        rd_end();

        // mid-op reset, then full recompute with A all 1: 4*255 = 1020
        for (int n = 0; n < 16; n++) ma[n] = 1;
        load_ab(1'b0);
        addrC = 4'd15;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        pulse_reset();
        run();
        for (int n = 0; n < 16; n++) rd(n, 1020);
        rd_end();

        // host clear of one C element, neighbour untouched
        @(posedge clk); #1 load_mem = 1'b1; wenC = 1'b1; addrC = 4'd5;
        @(posedge clk); #1 load_mem = 1'b0; wenC = 1'b0;
        rd(5, 0);
        rd(6, 1020);
        rd_end();

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
